// File: rtl/cordic_angle_seq.sv
// Angle sweep sequencer feeding cordic8bit, with LATENCY-deep valid/index tag delay line.
// Optional build macro: CORDIC_ANGLE_CLAMP_EN saturates latched angles to [-100, +100].
module cordic_angle_seq #(
    parameter int unsigned LATENCY = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] start_angle,
    input  logic [7:0] end_angle,
    input  logic [7:0] step,
    input  logic       mode,
    output logic [7:0] in_angle,
    output logic       angle_valid,
    output logic       busy,
    output logic       res_valid,
    output logic [7:0] res_index,
    output logic       done
);

    localparam int unsigned AW = 8;
    localparam int unsigned XW = 10;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   start_q, start_d, end_q, end_d, step_q, step_d;
    logic            mode_q, mode_d, dir_q, dir_d, first_q, first_d;
    logic [AW-1:0]   cnt_q, cnt_d, idx_q, idx_d;
    logic [CW-1:0]   drain_q, drain_d;
    logic [AW-1:0]   angle_d;
    logic            valid_d, busy_d, done_d;
    logic            emit;
    logic [AW-1:0]   emit_val;
    logic            vld_dl [LATENCY];
    logic [AW-1:0]   idx_dl [LATENCY];

    logic signed [XW-1:0] cur_x, start_x, end_x, step_x, up_x, dn_x;
    logic                 up_ok, dn_ok;

    function automatic logic [AW-1:0] sat_angle(input logic [AW-1:0] v);
`ifdef CORDIC_ANGLE_CLAMP_EN
        if ($signed(v) < -8'sd100)     return 8'h9C;
        else if ($signed(v) > 8'sd100) return 8'h64;
        else                           return v;
`else
        return v;
`endif
    endfunction

    // 10-bit sign-extended next-value arithmetic keeps bound checks free of wrap-around
    assign cur_x   = {{2{in_angle[AW-1]}}, in_angle};
    assign start_x = {{2{start_q[AW-1]}}, start_q};
    assign end_x   = {{2{end_q[AW-1]}}, end_q};
    assign step_x  = {2'b00, step_q};
    assign up_x    = cur_x + step_x;
    assign dn_x    = cur_x - step_x;
    assign up_ok   = (up_x <= end_x);
    assign dn_ok   = (dn_x >= start_x);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        end_d    = end_q;
        step_d   = step_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        first_d  = first_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        angle_d  = in_angle;
        valid_d  = 1'b0;
        busy_d   = busy;
        done_d   = 1'b0;
        emit     = 1'b0;
        emit_val = in_angle;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = SWEEP;
                    busy_d  = 1'b1;
                    start_d = sat_angle(start_angle);
                    end_d   = sat_angle(end_angle);
                    step_d  = (step == '0) ? AW'(1) : step;
                    mode_d  = mode;
                    dir_d   = 1'b0;
                    first_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                busy_d = 1'b1;
                if (first_q) begin
                    first_d = 1'b0;
                    if (start_x > end_x) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        emit     = 1'b1;
                        emit_val = start_q;
                    end
                end else if (stop) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else if (!dir_q) begin
                    if (up_ok) begin
                        emit     = 1'b1;
                        emit_val = AW'(up_x);
                    end else if (!mode_q) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        // turning point at the top; a lone value repeats itself
                        emit     = 1'b1;
                        emit_val = dn_ok ? AW'(dn_x) : in_angle;
                        dir_d    = dn_ok;
                    end
                end else begin
                    emit = 1'b1;
                    if (dn_ok) begin
                        emit_val = AW'(dn_x);
                    end else begin
                        emit_val = up_ok ? AW'(up_x) : in_angle;
                        dir_d    = 1'b0;
                    end
                end
            end
            DRAIN: begin
                busy_d = 1'b1;
                if (drain_q == CW'(LATENCY - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            angle_d = emit_val;
            valid_d = 1'b1;
            idx_d   = cnt_q;
            cnt_d   = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q     <= '0;
            end_q       <= '0;
            step_q      <= '0;
            mode_q      <= 1'b0;
            dir_q       <= 1'b0;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            in_angle    <= '0;
            angle_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            start_q     <= start_d;
            end_q       <= end_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            in_angle    <= angle_d;
            angle_valid <= valid_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Tag delay line aligning valid/index with the CORDIC result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                vld_dl[i] <= 1'b0;
                idx_dl[i] <= '0;
            end
        end else begin
            vld_dl[0] <= angle_valid;
            idx_dl[0] <= idx_q;
            for (int i = 1; i < int'(LATENCY); i++) begin
                vld_dl[i] <= vld_dl[i-1];
                idx_dl[i] <= idx_dl[i-1];
            end
        end
    end

    assign res_valid = vld_dl[LATENCY-1];
    assign res_index = idx_dl[LATENCY-1];

endmodule

// File: tb/tb_cordic_angle_seq.sv
// Directed scoreboard bench for cordic_angle_seq (LATENCY = 15).
module tb_cordic_angle_seq;

    localparam int LAT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] start_angle = '0;
    logic [7:0] end_angle = '0;
    logic [7:0] step = '0;
    logic       mode = 1'b0;
    logic [7:0] in_angle;
    logic       angle_valid;
    logic       busy;
    logic       res_valid;
    logic [7:0] res_index;
    logic       done;

    int n_pass = 0;
    int n_checks = 0;
    int ang_q[$];
    int res_q[$];

    cordic_angle_seq #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .start_angle(start_angle), .end_angle(end_angle), .step(step), .mode(mode),
        .in_angle(in_angle), .angle_valid(angle_valid), .busy(busy),
        .res_valid(res_valid), .res_index(res_index), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int clampv(input int v);
`ifdef CORDIC_ANGLE_CLAMP_EN
        if (v < -100) return -100;
        if (v > 100)  return 100;
`endif
        return v;
    endfunction

    // Reference sweep: ascending list, then ping-pong over it in bounce mode
    task automatic build_expect(input int sa_raw, input int ea_raw, input int st_raw,
                                input int md, input int n_bounce, output int n);
        int vals[$];
        int sa, ea, st, pos, d;
        sa = clampv(sa_raw);
        ea = clampv(ea_raw);
        st = (st_raw == 0) ? 1 : st_raw;
        for (int a = sa; a <= ea; a += st) vals.push_back(a);
        ang_q.delete();
        res_q.delete();
        n = 0;
        if (vals.size() == 0) return;
        if (md == 0) begin
            foreach (vals[i]) ang_q.push_back(vals[i]);
        end else begin
            pos = 0;
            d = 1;
            for (int i = 0; i < n_bounce; i++) begin
                ang_q.push_back(vals[pos]);
                if (vals.size() > 1) begin
                    if (pos + d < 0 || pos + d >= vals.size()) d = -d;
                    pos += d;
                end
            end
        end
        n = ang_q.size();
        for (int i = 0; i < n; i++) res_q.push_back(i % 256);
    endtask

    task automatic run(input string tag, input int sa, input int ea, input int st, input int md,
                       input int stop_n, input int pulse_n);
        int exp_n, seen, rseen, k, first_a, last_a, first_r, last_r, done_k;
        bit got_done;
        build_expect(sa, ea, st, md, stop_n, exp_n);
        seen = 0; rseen = 0; first_a = -1; last_a = -1; first_r = -1; last_r = -1; done_k = -1;
        got_done = 1'b0;
        @(negedge clk);
        start_angle = 8'(sa);
        end_angle   = 8'(ea);
        step        = 8'(st);
        mode        = md[0];
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!got_done && k < 400) begin
            if (angle_valid) begin
                seen++;
                if (first_a < 0) first_a = k;
                last_a = k;
                if (ang_q.size() > 0) chk({tag, " angle"}, int'($signed(in_angle)), ang_q.pop_front());
                else chk({tag, " extra sample"}, seen, exp_n);
            end
            if (res_valid) begin
                rseen++;
                if (first_r < 0) first_r = k;
                last_r = k;
                if (res_q.size() > 0) chk({tag, " res_index"}, int'(res_index), res_q.pop_front());
                else chk({tag, " extra res_valid"}, rseen, exp_n);
            end
            if (done) begin
                got_done = 1'b1;
                done_k = k;
            end
            stop  = angle_valid && (seen == stop_n);
            start = angle_valid && (seen == pulse_n);
            if (start) begin
                start_angle = 8'(-50);
                end_angle   = 8'(90);
                step        = 8'd3;
                mode        = 1'b1;
            end
            if (!got_done) begin
                @(negedge clk);
                k++;
            end
        end
        stop = 1'b0;
        start = 1'b0;
        chk({tag, " done seen"}, int'(got_done), 1);
        chk({tag, " sample count"}, seen, exp_n);
        chk({tag, " res_valid count"}, rseen, exp_n);
        if (exp_n > 0) begin
            chk({tag, " first sample latency"}, first_a, 2);
            chk({tag, " first res latency"}, first_r, first_a + LAT);
            chk({tag, " done after last sample"}, done_k, last_a + LAT + 1);
            chk({tag, " done after last res"}, done_k, last_r + 1);
        end else begin
            chk({tag, " empty done latency"}, done_k, LAT + 2);
        end
        @(negedge clk);
        chk({tag, " done single pulse"}, int'(done), 0);
        chk({tag, " busy low after done"}, int'(busy), 0);
    endtask

    initial begin
        int n, bad;
        rst = 1'b0;
        #1;
        chk("reset outputs", int'({in_angle, angle_valid, busy, res_valid, res_index, done}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        run("full", -100, 100, 1, 0, -1, -1);
        run("coarse", 0, 20, 7, 0, -1, -1);
        run("bounce", 0, 20, 7, 1, 4, -1);
        run("bounce long", 0, 20, 7, 1, 11, -1);
        run("single bounce", 5, 8, 10, 1, 6, -1);
        run("empty", 10, 5, 1, 0, -1, -1);
        run("zero step", 0, 2, 0, 0, -1, -1);
        run("clamp", -128, 127, 50, 0, -1, -1);
        run("start ignored", 0, 20, 7, 0, -1, 1);

        // reset in the middle of a sweep
        build_expect(0, 100, 1, 0, 0, n);
        @(negedge clk);
        start_angle = 8'd0; end_angle = 8'd100; step = 8'd1; mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clk);
        chk("pre-reset busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("mid reset in_angle", int'(in_angle), 0);
        chk("mid reset flags", int'({angle_valid, busy, res_valid, done}), 0);
        chk("mid reset res_index", int'(res_index), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || res_valid || angle_valid || busy) bad++;
        end
        chk("post-reset quiet", bad, 0);
        run("after reset", 0, 20, 7, 0, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
